dpram_be_param: RTL
===================

// Module: dpram_be_param
//
// PURPOSE
// Parametrised true-dual-port RAM, successor to the fixed 2048x40 dual-port RAM.
// Adds per-byte write enables, port enables, selectable read latency (1 or 2),
// selectable same-port read-during-write mode, deterministic cross-port
// collision resolution, and read-valid tracking.
// Used as the weight/activation buffer in compute tiles; one instance per bank.
//
// PARAMETERS
// AWIDTH      11    address width; NUM_WORDS <= 2**AWIDTH
// NUM_WORDS   2048  number of words
// DWIDTH      40    data width; must be a multiple of 8
// BEWIDTH     5     byte-enable width; must equal DWIDTH/8
// RD_LATENCY  1     1 = registered read; 2 = extra output pipeline register
// WR_MODE     0     same-port read-during-write: 0 NO_CHANGE, 1 READ_FIRST, 2 WRITE_FIRST
//
// PORTS
// clk        in   1        clock, all state on rising edge
// resetn     in   1        asynchronous active-low reset
// en_a       in   1        port A enable; no read or write when 0
// wren_a     in   1        port A write (qualified by en_a)
// be_a       in   BEWIDTH  port A byte enables; bit i covers data[8i+7:8i]
// address_a  in   AWIDTH   port A address
// data_a     in   DWIDTH   port A write data
// out_a      out  DWIDTH   port A read data
// valid_a    out  1        out_a holds data for a read issued RD_LATENCY cycles earlier
// en_b, wren_b, be_b, address_b, data_b, out_b, valid_b   same as port A
// collision  out  1        registered pulse: both ports wrote the same address last cycle
//
// BEHAVIOUR
// - Reset (resetn=0, async): out_a/out_b=0, valid_a/valid_b=0, collision=0,
//   all pipeline stages cleared; in-flight reads discarded. Memory array NOT reset.
// - Read: en=1 & wren=0 at edge N -> out=mem[addr] and valid=1 after edge
//   N+RD_LATENCY-1 (visible in cycle N+1 for latency 1, N+2 for latency 2).
// - valid is one per issued read; deasserts when no read lands that cycle.
//   out holds its last value when valid=0 (not cleared).
// - Write: en=1 & wren=1 -> bytes with be[i]=1 updated at edge; be=0 is a no-op
//   write. A write with be=0 is still a write for mode and valid purposes.
// - Same-port write, WR_MODE: 0 -> out unchanged, valid=0; 1 -> out=old word,
//   valid=1; 2 -> out=new merged word (old bytes where be=0), valid=1.
// - Cross-port write/write, same address, same edge: per byte, port A wins where
//   be_a[i]=1, port B's byte written where only be_b[i]=1; collision=1 next cycle
//   only if both wrens were set (any be overlap or not).
// - Cross-port read/write, same address: reader returns OLD word (read-before-write).
// - Addresses >= NUM_WORDS: writes ignored, reads return 0 with valid=1.
// - RD_LATENCY=2 pipeline: stage-1 register feeds out; both stages and valid
//   advance every cycle (no stall input).
// - Parameter checks: BEWIDTH!=DWIDTH/8 or RD_LATENCY not in {1,2} -> elaboration error.
//
// TESTING
// 1. Write A addr 5 = 0x12_3456_789A be=all, read B addr 5 next cycle -> out_b=0x123456789A,
//    valid_b=1 one cycle later (RD_LATENCY=1) / two cycles later (RD_LATENCY=2).
// 2. Preload addr 7=0xFFFFFFFFFF; write A data 0 be=5'b00101 -> read gives 0xFFFF00FF00.
// 3. Both ports write addr 9 same edge, A=0x1111111111 be=5'b00011, B=0x2222222222
//    be=5'b11110 -> addr 9 = 0x2222221111, collision=1 for exactly one cycle.
// 4. Addr 3=0xAA..AA; A writes 0x55..55 to 3 while B reads 3 -> out_b=0xAAAAAAAAAA;
//    WR_MODE 0/1/2 on port A -> out_a unchanged & valid_a=0 / 0xAA..AA / 0x55..55.
// 5. RD_LATENCY=2, back-to-back reads addr 0..3 every cycle -> valid_b high 4 cycles,
//    data in order; resetn pulsed low mid-burst -> outputs/valid 0 immediately,
//    no stale valid after release, memory contents intact on re-read.
// 6. Read addr NUM_WORDS (AWIDTH=12, NUM_WORDS=2048) -> out=0, valid=1; write there ignored.

Source files
------------

// File: rtl/dpram_be_param.sv
// Parametrised true-dual-port RAM with per-byte write enables, port enables,
// read latency of 1 or 2, selectable same-port read-during-write behaviour,
// cross-port collision flag and per-port read-valid tracking.
module dpram_be_param #(
    parameter int AWIDTH     = 11,
    parameter int NUM_WORDS  = 2048,
    parameter int DWIDTH     = 40,
    parameter int BEWIDTH    = 5,
    parameter int RD_LATENCY = 1,
    parameter int WR_MODE    = 0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               en_a,
    input  logic               wren_a,
    input  logic [BEWIDTH-1:0] be_a,
    input  logic [AWIDTH-1:0]  address_a,
    input  logic [DWIDTH-1:0]  data_a,
    output logic [DWIDTH-1:0]  out_a,
    output logic               valid_a,
    input  logic               en_b,
    input  logic               wren_b,
    input  logic [BEWIDTH-1:0] be_b,
    input  logic [AWIDTH-1:0]  address_b,
    input  logic [DWIDTH-1:0]  data_b,
    output logic [DWIDTH-1:0]  out_b,
    output logic               valid_b,
    output logic               collision
);
    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [AWIDTH:0] LIM = (AWIDTH+1)'(NUM_WORDS);

    if ((DWIDTH % 8) != 0 || BEWIDTH != DWIDTH / 8) begin : g_bad_be
        $error("dpram_be_param: BEWIDTH must equal DWIDTH/8");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
        $error("dpram_be_param: RD_LATENCY must be 1 or 2");
    end

    logic [DWIDTH-1:0] r_mem [NUM_WORDS];

    logic              w_ina, w_inb, w_wa, w_wb;
    logic [IW-1:0]     w_ia, w_ib;
    logic [DWIDTH-1:0] w_old_a, w_old_b, w_new_a, w_new_b, w_ld_a, w_ld_b;
    logic              w_lv_a, w_lv_b;
    logic [DWIDTH-1:0] r_d1_a, r_d1_b;
    logic              r_v1_a, r_v1_b, r_coll;

    assign w_ina   = {1'b0, address_a} < LIM;
    assign w_inb   = {1'b0, address_b} < LIM;
    assign w_ia    = address_a[IW-1:0];
    assign w_ib    = address_b[IW-1:0];
    assign w_wa    = en_a & wren_a & w_ina;
    assign w_wb    = en_b & wren_b & w_inb;
    // Out-of-range addresses read as zero; the array is never touched for them
    assign w_old_a = w_ina ? r_mem[w_ia] : '0;
    assign w_old_b = w_inb ? r_mem[w_ib] : '0;

    // Merged post-write word as each port sees it (old bytes where be=0)
    always_comb begin
        w_new_a = w_old_a;
        w_new_b = w_old_b;
        for (int i = 0; i < BEWIDTH; i++) begin
            if (be_a[i]) w_new_a[8*i +: 8] = data_a[8*i +: 8];
            if (be_b[i]) w_new_b[8*i +: 8] = data_b[8*i +: 8];
        end
        if (!w_ina) w_new_a = '0;
        if (!w_inb) w_new_b = '0;
    end

    // Decide what each port launches into the read pipeline this cycle
    always_comb begin
        w_lv_a = 1'b0;
        w_ld_a = w_old_a;
        w_lv_b = 1'b0;
        w_ld_b = w_old_b;
        if (en_a) begin
            if (!wren_a || WR_MODE == 1) begin
                w_lv_a = 1'b1;
            end else if (WR_MODE == 2) begin
                w_lv_a = 1'b1;
                w_ld_a = w_new_a;
            end
        end
        if (en_b) begin
            if (!wren_b || WR_MODE == 1) begin
                w_lv_b = 1'b1;
            end else if (WR_MODE == 2) begin
                w_lv_b = 1'b1;
                w_ld_b = w_new_b;
            end
        end
    end

    // Byte-lane writes; port A is assigned last so it owns shared bytes
    always_ff @(posedge clk) begin
        for (int i = 0; i < BEWIDTH; i++) begin
            if (w_wb && be_b[i]) r_mem[w_ib][8*i +: 8] <= data_b[8*i +: 8];
            if (w_wa && be_a[i]) r_mem[w_ia][8*i +: 8] <= data_a[8*i +: 8];
        end
    end

    // First read stage and collision flag; data holds when nothing launches
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_d1_a <= '0;
            r_d1_b <= '0;
            r_v1_a <= 1'b0;
            r_v1_b <= 1'b0;
            r_coll <= 1'b0;
        end else begin
            r_v1_a <= w_lv_a;
            r_v1_b <= w_lv_b;
            if (w_lv_a) r_d1_a <= w_ld_a;
            if (w_lv_b) r_d1_b <= w_ld_b;
            r_coll <= en_a & wren_a & en_b & wren_b & (address_a == address_b);
        end
    end

    assign collision = r_coll;

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DWIDTH-1:0] r_d2_a, r_d2_b;
        logic              r_v2_a, r_v2_b;
        // Output stage, free running behind stage 1
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_d2_a <= '0;
                r_d2_b <= '0;
                r_v2_a <= 1'b0;
                r_v2_b <= 1'b0;
            end else begin
                r_v2_a <= r_v1_a;
                r_v2_b <= r_v1_b;
                if (r_v1_a) r_d2_a <= r_d1_a;
                if (r_v1_b) r_d2_b <= r_d1_b;
            end
        end
        assign out_a   = r_d2_a;
        assign out_b   = r_d2_b;
        assign valid_a = r_v2_a;
        assign valid_b = r_v2_b;
    end else begin : g_lat1
        assign out_a   = r_d1_a;
        assign out_b   = r_d1_b;
        assign valid_a = r_v1_a;
        assign valid_b = r_v1_b;
    end
endmodule
